alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Captures each ALU result, with its destination register index, into a 2-entry in-order buffer with valid/ready handshakes on both sides.
- Holds the architectural status flags (C, Z, N, V).
- Feeds the registered carry back to the ALU CI input so ADDC/SUB chains use the previous op's carry.

Parameters:
- WIDTH, 16, data path width of the result and the buffer entries.
- REG_BITS, 3, width of the destination register index.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- In_Valid  input  1  ALU result presented this cycle.
- In_Ready  output  1  stage can accept an entry; equals (count < 2), driven from registered state only.
- Res  input  WIDTH  ALU result.
- CO  input  1  ALU carry/borrow out.
- OV  input  1  ALU signed overflow.
- Rd  input  REG_BITS  destination register index.
- Flag_We  input  1  this op updates the flags (decoded upstream from Op).
- Set_C  input  1  force C=1 (SEC).
- Clr_C  input  1  force C=0 (CLC).
- Out_Valid  output  1  buffer head valid.
- Out_Ready  input  1  register file accepts the head.
- Out_Res  output  WIDTH  head result.
- Out_Rd  output  REG_BITS  head destination index.
- Flags  output  4  {V,N,Z,C}: [0]=C, [1]=Z, [2]=N, [3]=V.
- CI  output  1  carry to ALU; equals Flags[0].

Behaviour:
- Reset (async, Rst_n=0):
  - count=0, Out_Valid=0, Out_Res=0, Out_Rd=0, Flags=4'b0000, CI=0.
  - In_Ready=1 while in reset and after release.
- Mid-operation reset drops all buffered entries immediately; no partial output.
- Push: In_Valid && In_Ready at a rising edge writes {Res,Rd} to the tail.
- Pop: Out_Valid && Out_Ready at a rising edge removes the head.
- Strict FIFO order. Head always on Out_*. Out_Valid = (count != 0).
- Latency: an entry pushed at edge k is visible on Out_* from edge k onward (one cycle after presentation) if the buffer was empty.
- Simultaneous push and pop:
  - count=1: count stays 1; the new entry becomes head after the edge.
  - count=2: In_Ready=0, so no push that cycle, even if a pop occurs. No combinational ready path.
- Out_Res/Out_Rd hold their last value when Out_Valid=0.
- Flags update only on an accepted push with Flag_We=1:
  - C <= CO
  - Z <= (Res == 0)
  - N <= Res[WIDTH-1]
  - V <= OV
- A push with Flag_We=0 leaves Flags unchanged. In_Valid without In_Ready never touches Flags.
- Flag priority, per edge: reset > (accepted push with Flag_We) > Set_C > Clr_C. Set_C/Clr_C affect only C.
- Flags update at push, not at pop: the next ALU op sees the new CI one cycle after its predecessor is accepted, regardless of output backpressure.
- Out_Ready while Out_Valid=0 has no effect.

Optional Feature:
- Macro: ALU_WB_FWD_EN.
- Defined: adds outputs Fwd_Valid (1), Fwd_Rd (REG_BITS), Fwd_Res (WIDTH) for operand bypass.
  - Fwd_Valid = 1 when the newest buffered entry (tail-1) exists, i.e. count != 0.
  - Fwd_Rd/Fwd_Res carry that entry's fields.
  - When count=2 they expose the younger entry; when count=1 they equal Out_*.
  - Reset value 0 for all three.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then ADD result: push Res=16'h0000, CO=1, OV=0, Flag_We=1 -> next cycle Flags=4'b0011, CI=1, Out_Valid=1, Out_Res=16'h0000.
- Signed overflow: push Res=16'h8000, CO=0, OV=1, Flag_We=1 -> Flags=4'b1100, CI=0.
- Backpressure: Out_Ready=0, push Rd=1,2,3 on consecutive cycles -> In_Ready falls after 2 pushes, third held. Then Out_Ready=1 -> Out_Rd sequence 1,2,3, with no loss or duplication.
- Flag_We=0 push, then Set_C with an accepted Flag_We=1 push of CO=0 in the same cycle -> C=0 (push wins). Set_C alone next cycle -> C=1, Z/N/V unchanged.
- Rst_n pulsed low with count=2 -> Out_Valid=0, Flags=0, In_Ready=1 immediately, without waiting for a clock.
- With ALU_WB_FWD_EN: push Rd=5/Res=16'h1234 then Rd=6/Res=16'hABCD with Out_Ready=0 -> Fwd_Rd=6, Fwd_Res=16'hABCD, Out_Rd=5.

Source files
------------

// File: rtl/alu_wb_stage.sv
// ALU write-back stage: 2-entry in-order result buffer plus architectural C/Z/N/V flags.
// Define ALU_WB_FWD_EN to add the Fwd_* bypass outputs exposing the newest buffered entry.
module alu_wb_stage #(
    parameter int WIDTH    = 16,
    parameter int REG_BITS = 3
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                In_Valid,
    output logic                In_Ready,
    input  logic [WIDTH-1:0]    Res,
    input  logic                CO,
    input  logic                OV,
    input  logic [REG_BITS-1:0] Rd,
    input  logic                Flag_We,
    input  logic                Set_C,
    input  logic                Clr_C,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic [WIDTH-1:0]    Out_Res,
    output logic [REG_BITS-1:0] Out_Rd,
    output logic [3:0]          Flags,
    output logic                CI
`ifdef ALU_WB_FWD_EN
    ,
    output logic                Fwd_Valid,
    output logic [REG_BITS-1:0] Fwd_Rd,
    output logic [WIDTH-1:0]    Fwd_Res
`endif
);

    localparam int EW = WIDTH + REG_BITS;

    // Entries packed as {rd, res}; head_q is always the oldest, tail_q only meaningful at count 2.
    logic [EW-1:0] head_q, head_d;
    logic [EW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic [3:0]    flags_q, flags_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] new_entry;

    assign In_Ready  = (count_q < 2'd2);
    assign Out_Valid = (count_q != 2'd0);
    assign push      = In_Valid && In_Ready;
    assign pop       = Out_Valid && Out_Ready;
    assign new_entry = {Rd, Res};

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push && pop) begin
            // Only reachable with count 1: the incoming entry replaces the departing head.
            head_d = new_entry;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_d = new_entry;
            end else begin
                tail_d = new_entry;
            end
            count_d = count_q + 2'd1;
        end else if (pop) begin
            // On the last pop the head is left in place so Out_* keeps its final value.
            if (count_q == 2'd2) begin
                head_d = tail_q;
            end
            count_d = count_q - 2'd1;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (push && Flag_We) begin
            flags_d[0] = CO;
            flags_d[1] = (Res == '0);
            flags_d[2] = Res[WIDTH-1];
            flags_d[3] = OV;
        end else if (Set_C) begin
            flags_d[0] = 1'b1;
        end else if (Clr_C) begin
            flags_d[0] = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            flags_q <= 4'b0000;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    assign Out_Res = head_q[WIDTH-1:0];
    assign Out_Rd  = head_q[EW-1:WIDTH];
    assign Flags   = flags_q;
    assign CI      = flags_q[0];

`ifdef ALU_WB_FWD_EN
    logic [EW-1:0] fwd_entry;

    assign fwd_entry = (count_q == 2'd2) ? tail_q : head_q;
    assign Fwd_Valid = (count_q != 2'd0);
    assign Fwd_Res   = fwd_entry[WIDTH-1:0];
    assign Fwd_Rd    = fwd_entry[EW-1:WIDTH];
`endif

endmodule
